// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit sequencer.
// Holds the frame width, frame counter width and sequencer state encoding.
package spi_pkg;

    localparam int SPI_WORD_W  = 11;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_tx_fifo.sv
// Single-clock FIFO buffering producer words ahead of the SPI sequencer.
// Full/empty come from the registered occupancy count; pointers wrap naturally.
module spi_tx_fifo #(
    parameter int WORD_W = 11,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WORD_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [WORD_W-1:0]          o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("spi_tx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    // Guards make the FIFO safe even if a caller ignores full/empty.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/spi_tx_sequencer.sv
// Feeds buffered words to the SPI top one frame at a time with an inter-frame gap.
// Optional WAIT_DONE watchdog enabled by defining SPI_TX_TIMEOUT_EN.
module spi_tx_sequencer
    import spi_pkg::*;
#(
    parameter int WORD_W         = SPI_WORD_W,
    parameter int DEPTH          = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WORD_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       new_d,
    output logic [WORD_W-1:0]          d_out,
    input  logic                       done_in,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [FRAME_CNT_W-1:0]     frames_sent,
    output logic                       err_timeout,
    output spi_state_e                 o_dbg_state
);

    localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    if (GAP_CYCLES < 0) begin : g_bad_gap
        $error("spi_tx_sequencer: GAP_CYCLES must be non-negative");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("spi_tx_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    spi_state_e           r_state;
    spi_state_e           w_next;
    logic [WORD_W-1:0]    r_d_out;
    logic [FRAME_CNT_W-1:0] r_frames_sent;
    logic [GW-1:0]        r_gap_cnt;
    logic                 w_pop;
    logic                 w_frame_done;
    logic                 w_timeout;
    logic                 w_full;
    logic                 w_empty;
    logic [WORD_W-1:0]    w_head;

    // Producer handshake: a word transfers on a clock edge where in_valid && in_ready;
    // in_ready depends only on registered occupancy, never on a same-cycle pop.
    spi_tx_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

`ifdef SPI_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != WAIT_DONE)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // done_in has priority over an expiring watchdog in the same cycle.
    assign w_timeout = (r_state == WAIT_DONE) && !done_in
                       && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_pop  = 1'b1;
                w_next = ISSUE;
            end
            ISSUE: begin
                w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_in) begin
                    w_frame_done = 1'b1;
                    w_next       = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (w_timeout) begin
                    w_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != GAP)) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_out <= '0;
        end else if (w_pop) begin
            r_d_out <= w_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames_sent <= '0;
        end else if (w_frame_done) begin
            r_frames_sent <= r_frames_sent + 1'b1;
        end
    end

    assign in_ready    = !w_full;
    assign new_d       = (r_state == ISSUE);
    assign d_out       = r_d_out;
    assign busy        = (r_state != IDLE);
    assign frames_sent = r_frames_sent;
    assign err_timeout = w_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Self-checking bench for spi_tx_sequencer: directed scenarios plus random traffic
// checked against a transaction-level model (word queue, frame counter, gap timing).
module tb_spi_tx_sequencer;
    import spi_pkg::*;

    localparam int W      = 11;
    localparam int DEPTH  = 8;
    localparam int GAP_N  = 4;
    localparam int TO_N   = 16;
    localparam int CW     = $clog2(DEPTH + 1);
`ifdef SPI_TX_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          new_d;
    logic [W-1:0]  d_out;
    logic          done_in;
    logic          done_auto;
    logic          done_man;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic [15:0]   frames_sent;
    logic          err_timeout;
    spi_state_e    dbg_state;

    assign done_in = done_auto | done_man;

    spi_tx_sequencer #(
        .WORD_W         (W),
        .DEPTH          (DEPTH),
        .GAP_CYCLES     (GAP_N),
        .TIMEOUT_CYCLES (TO_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .new_d       (new_d),
        .d_out       (d_out),
        .done_in     (done_in),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .frames_sent (frames_sent),
        .err_timeout (err_timeout),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_cur;
    logic [15:0]  m_frames;
    bit           m_wait;
    int           m_wait_cyc;
    int           cyc;
    int           last_done_cyc;
    int           n_err_seen;
    int           n_checks;
    int           n_pass;
    bit           auto_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks (start/end at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done_man = 1'b1;
        @(posedge clk);
        #1;
        done_man = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        done_man = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_wait        = 1'b0;
        m_frames      = '0;
        last_done_cyc = -1;
        n_err_seen    = 0;
        rst           = 1'b0;
    endtask

    task automatic wait_issue(input int max_cyc);
        int n;
        n = 0;
        while (!m_wait && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("issue_within_budget", {31'b0, m_wait}, 32'd1);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((m_wait || exp_q.size() != 0 || busy) && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_within_budget", {31'b0, (n < max_cyc)}, 32'd1);
    endtask

    // ---------------- done responder ----------------
    initial begin
        done_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (new_d && auto_en && !rst) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 done_auto = 1'b1;
                @(posedge clk);
                #1 done_auto = 1'b0;
            end
        end
    end

    // ---------------- monitor / reference model ----------------
    initial begin
        bit exp_err;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                exp_err = 1'b0;
                chk("frames_sent", {16'b0, frames_sent}, {16'b0, m_frames});
                if (new_d) begin
                    chk("new_d_while_frame_open", {31'b0, m_wait}, 32'd0);
                    chk("new_d_has_pending_word", {31'b0, (exp_q.size() > 0)}, 32'd1);
                    if (exp_q.size() > 0) begin
                        chk("d_out_at_issue", {21'b0, d_out}, {21'b0, exp_q[0]});
                        if (last_done_cyc >= 0) begin
                            chk("inter_frame_gap", {31'b0, ((cyc - last_done_cyc - 1) >= GAP_N)}, 32'd1);
                        end
                        m_cur = exp_q.pop_front();
                    end
                    m_wait     = 1'b1;
                    m_wait_cyc = 0;
                end else if (m_wait) begin
                    m_wait_cyc++;
                    chk("d_out_hold", {21'b0, d_out}, {21'b0, m_cur});
                    chk("busy_in_frame", {31'b0, busy}, 32'd1);
                    chk("count_in_frame", {28'b0, fifo_count}, exp_q.size());
                    chk("ready_in_frame", {31'b0, in_ready}, {31'b0, (exp_q.size() < DEPTH)});
                    if (done_in) begin
                        m_frames      = m_frames + 16'd1;
                        m_wait        = 1'b0;
                        last_done_cyc = cyc;
                    end else if (TO_ON && m_wait_cyc == TO_N) begin
                        exp_err       = 1'b1;
                        m_wait        = 1'b0;
                        last_done_cyc = cyc;
                    end
                end
                chk("err_timeout", {31'b0, err_timeout}, {31'b0, exp_err});
                if (err_timeout) n_err_seen++;
                if (in_valid && in_ready) exp_q.push_back(in_data);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        done_man = 1'b0;
        auto_en  = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        m_frames = '0;
        m_wait   = 1'b0;
        last_done_cyc = -1;
        n_err_seen    = 0;

        // 1: reset values, single-word latency, gap length
        do_reset();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_new_d", {31'b0, new_d}, 32'd0);
        chk("rst_d_out", {21'b0, d_out}, 32'd0);
        chk("rst_count", {28'b0, fifo_count}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_state", {29'b0, dbg_state}, {29'b0, IDLE});
        send(11'h5A5);
        idle(1);
        chk("t1_no_early_new_d", {31'b0, new_d}, 32'd0);
        idle(1);
        chk("t1_new_d", {31'b0, new_d}, 32'd1);
        chk("t1_d_out", {21'b0, d_out}, 32'h5A5);
        idle(1);
        chk("t1_new_d_single", {31'b0, new_d}, 32'd0);
        pulse_done();
        chk("t1_frames", {16'b0, frames_sent}, 32'd1);
        idle(GAP_N - 1);
        chk("t1_busy_in_gap", {31'b0, busy}, 32'd1);
        idle(1);
        chk("t1_idle_after_gap", {31'b0, busy}, 32'd0);

        // 2: fill FIFO behind an open frame, refuse 9th push, drain in order
        do_reset();
        send(11'h3C3);
        wait_issue(20);
        for (int i = 1; i <= 8; i++) send(W'(i));
        chk("t2_count_full", {28'b0, fifo_count}, 32'd8);
        chk("t2_ready_low", {31'b0, in_ready}, 32'd0);
        send(11'h1FF);
        chk("t2_count_after_refuse", {28'b0, fifo_count}, 32'd8);
        auto_en = 1'b1;
        pulse_done();
        wait_drain(400);
        chk("t2_frames", {16'b0, frames_sent}, 32'd9);
        auto_en = 1'b0;

        // 3: reset during WAIT_DONE with words queued
        do_reset();
        send(11'h111);
        wait_issue(20);
        send(11'h222);
        send(11'h333);
        send(11'h444);
        chk("t3_count_before_rst", {28'b0, fifo_count}, 32'd3);
        do_reset();
        chk("t3_state", {29'b0, dbg_state}, {29'b0, IDLE});
        chk("t3_count", {28'b0, fifo_count}, 32'd0);
        chk("t3_new_d", {31'b0, new_d}, 32'd0);
        idle(30);
        chk("t3_still_idle", {31'b0, busy}, 32'd0);

        // 4: done_in outside WAIT_DONE is ignored
        do_reset();
        done_man = 1'b1;
        idle(2);
        done_man = 1'b0;
        chk("t4_frames_after_stray_done", {16'b0, frames_sent}, 32'd0);
        send(11'h7FF);
        wait_issue(20);
        idle(2);
        chk("t4_frames_before_done", {16'b0, frames_sent}, 32'd0);
        pulse_done();
        chk("t4_frames_after_done", {16'b0, frames_sent}, 32'd1);
        wait_drain(50);

        // 5: done_in withheld
        do_reset();
        send(11'h2AA);
        send(11'h155);
        wait_issue(20);
`ifdef SPI_TX_TIMEOUT_EN
        auto_en = 1'b1;
        wait_drain(200);
        chk("t5_err_pulses", n_err_seen, 32'd1);
        chk("t5_frames", {16'b0, frames_sent}, 32'd1);
        auto_en = 1'b0;
`else
        idle(200);
        chk("t5_busy_held", {31'b0, busy}, 32'd1);
        chk("t5_state_wait", {29'b0, dbg_state}, {29'b0, WAIT_DONE});
        chk("t5_frames", {16'b0, frames_sent}, 32'd0);
`endif

        // 6: frame counter wrap
        do_reset();
        force dut.r_frames_sent = 16'hFFFF;
        m_frames = 16'hFFFF;
        idle(1);
        release dut.r_frames_sent;
        chk("t6_preload", {16'b0, frames_sent}, 32'hFFFF);
        auto_en = 1'b1;
        send(11'h0F0);
        wait_drain(50);
        chk("t6_wrap", {16'b0, frames_sent}, 32'h0000);

        // random traffic
        do_reset();
        auto_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) send(W'($urandom));
            else idle(1);
        end
        wait_drain(3000);
        chk("rand_queue_empty", exp_q.size(), 32'd0);
        chk("rand_count_zero", {28'b0, fifo_count}, 32'd0);
        auto_en = 1'b0;
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
